mem_wb_stage: RTL and testbench
===============================

# mem_wb_stage

Memory-access and write-back stage of the 16-bit MIPS pipeline, directly downstream of `execution_block`. Takes the registered ALU result, store data and flags, performs data-memory loads and stores against an internal word-addressed RAM, resolves conditional jumps from the flags, and drives the register-file write port. It also owns the processor halt state entered on `HLT`.

## Interface
- `DM_DEPTH`, 256: data-memory words; must be a power of two.
- `DM_AW`, 8: data-memory address width, equal to log2(`DM_DEPTH`).
- `RF_AW`, 3: register-file address width.
- `clk`  in  1  pipeline clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `op_ex`  in  6  opcode aligned with `ans_ex`, using the execution-stage encoding.
- `ans_ex`  in  16  ALU result; this is the memory address for `LD`/`ST`.
- `DM_data`  in  16  store data.
- `flag_ex`  in  2  [0] overflow, [1] zero.
- `rd_ex`  in  RF_AW  destination register.
- `target_ex`  in  16  jump target.
- `wb_en`  out  1  register-file write enable.
- `wb_addr`  out  RF_AW  register-file write address.
- `wb_data`  out  16  register-file write data.
- `jump_taken`  out  1  one-cycle pulse; redirect fetch.
- `jump_addr`  out  16  redirect target.
- `addr_err`  out  1  sticky flag; set by an out-of-range `LD`/`ST`.
- `halted`  out  1  high while in the HALT state.

## Operation
- **FSM states:** RUN and HALT.
  - RUN → HALT on the edge where `op_ex` = `HLT`.
  - HALT → RUN only via reset.
  - In HALT: no memory writes, and `wb_en`/`jump_taken` are forced to 0.
- **Write-back opcodes:** ADD, SUB, MOV, AND, OR, XOR, NOT, ADI, SBI, MVI, ANI, ORI, XRI, NTI, LD, IN, LS, RS, RSA.
  - For these, `wb_en` = 1 and `wb_addr` = `rd_ex`.
  - `wb_data` = `ans_ex`, except for `LD`, where `wb_data` = mem[`ans_ex`[DM_AW-1:0]].
  - All other opcodes, including undefined encodings, give `wb_en` = 0.
- **ST:** writes mem[`ans_ex`[DM_AW-1:0]] ← `DM_data`.
- **Address range check:** applies to `LD`/`ST` when `ans_ex`[15:DM_AW] ≠ 0.
  - `ST`: the write is suppressed.
  - `LD`: `wb_data` = 0 with `wb_en` = 1.
  - In both cases `addr_err` sets and stays set until reset.
- **Jumps:** `JMP` is always taken. `JV` is taken if `flag_ex`[0], `JNV` if !`flag_ex`[0], `JZ` if `flag_ex`[1], `JNZ` if !`flag_ex`[1]. When taken, `jump_taken` = 1 and `jump_addr` = `target_ex`.
- **Other opcodes:** `RET`, `OUT` and `HLT` write nothing and take no jump.
- **Memory contents:** not cleared by reset; they are undefined until written.

## Timing
- All outputs are registered.
- Latency is exactly one cycle: inputs sampled at edge N appear on the outputs after edge N, including `LD` data (synchronous RAM read at edge N).
- **ST then LD:** an `ST` at edge N followed by an `LD` of the same address at edge N+1 returns the new data. No forwarding is needed because only one memory op occurs per cycle.
- **Pulse width:** `jump_taken` and `wb_en` reflect only the current op. They hold no value past one cycle unless the next op also asserts them.
- **HLT cycle:** the `HLT` op produces `wb_en` = 0, and `halted` = 1 from the following cycle.
- **Reset values**, applied at any edge with `reset` = 0, including mid-halt:
  - `wb_en`, `jump_taken`, `addr_err`, `halted` = 0.
  - `wb_addr` = 0, `wb_data` = 0, `jump_addr` = 0.
  - FSM = RUN.
  - A store presented in the same cycle as reset is dropped.

## Structure
- Package `mips16_pkg` holds:
  - the 6-bit opcode constants (ADD … JNZ), shared with `execution_block` and decode;
  - the flag bit indices (OVF = 0, ZERO = 1);
  - the FSM state encoding.
- Sub-module `dm_ram`: single-port synchronous RAM (`DM_DEPTH` × 16) with write enable, registered read data, and read-during-write returning the old data. Stage logic never reads and writes the same cycle.
- The remaining logic is opcode decode, the FSM and the output registers, all inline.

## Test plan
- **Reset:** hold `reset` = 0 for 2 cycles with `op_ex` = ST, `ans_ex` = 5, `DM_data` = 16'hBEEF; release, then LD addr 5. Required: all outputs 0 during reset, and the LD does not return BEEF (store dropped).
- **ST/LD back-to-back:** ST addr 16'h0012 data 16'h1234, next cycle LD addr 16'h0012 with `rd_ex` = 3. Required: one cycle later `wb_en` = 1, `wb_addr` = 3, `wb_data` = 16'h1234.
- **ALU write-back:** ADD with `ans_ex` = 16'h00FF, `rd_ex` = 7. Required: `wb_en` = 1, `wb_data` = 16'h00FF next cycle. Then OUT, which gives `wb_en` = 0.
- **Out of range:** ST addr 16'h0100 (with DM_AW = 8), then LD addr 16'h0000. Required: address 0 is unchanged, and `addr_err` = 1 and stays high through 10 further ALU ops.
- **Jumps:** JZ with `flag_ex` = 2'b10, `target_ex` = 16'h0040 gives `jump_taken` = 1, `jump_addr` = 16'h0040. JNZ with the same flags gives `jump_taken` = 0. JNV with `flag_ex` = 2'b00 is taken.
- **Halt:** HLT, then ADD `rd_ex` = 1 and JMP. Required: `halted` = 1 and no `wb_en`/`jump_taken` pulses; after reset, `halted` = 0 and ADD writes back normally.

Source files
------------

// File: rtl/mips16_pkg.sv
// Shared definitions for the 16-bit MIPS pipeline: opcode encoding, flag
// bit positions and the memory/write-back stage FSM encoding.
package mips16_pkg;

    localparam logic [5:0] OP_ADD = 6'd0;
    localparam logic [5:0] OP_SUB = 6'd1;
    localparam logic [5:0] OP_MOV = 6'd2;
    localparam logic [5:0] OP_AND = 6'd3;
    localparam logic [5:0] OP_OR  = 6'd4;
    localparam logic [5:0] OP_XOR = 6'd5;
    localparam logic [5:0] OP_NOT = 6'd6;
    localparam logic [5:0] OP_ADI = 6'd7;
    localparam logic [5:0] OP_SBI = 6'd8;
    localparam logic [5:0] OP_MVI = 6'd9;
    localparam logic [5:0] OP_ANI = 6'd10;
    localparam logic [5:0] OP_ORI = 6'd11;
    localparam logic [5:0] OP_XRI = 6'd12;
    localparam logic [5:0] OP_NTI = 6'd13;
    localparam logic [5:0] OP_RET = 6'd14;
    localparam logic [5:0] OP_HLT = 6'd15;
    localparam logic [5:0] OP_LD  = 6'd16;
    localparam logic [5:0] OP_ST  = 6'd17;
    localparam logic [5:0] OP_IN  = 6'd18;
    localparam logic [5:0] OP_OUT = 6'd19;
    localparam logic [5:0] OP_JMP = 6'd20;
    localparam logic [5:0] OP_LS  = 6'd21;
    localparam logic [5:0] OP_RS  = 6'd22;
    localparam logic [5:0] OP_RSA = 6'd23;
    localparam logic [5:0] OP_JV  = 6'd24;
    localparam logic [5:0] OP_JNV = 6'd25;
    localparam logic [5:0] OP_JZ  = 6'd26;
    localparam logic [5:0] OP_JNZ = 6'd27;

    localparam int FLAG_OVF  = 0;
    localparam int FLAG_ZERO = 1;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } wb_state_t;

    // Opcodes that write the register file (LD included).
    function automatic logic writes_back(input logic [5:0] op);
        logic res;
        case (op)
            OP_ADD, OP_SUB, OP_MOV, OP_AND, OP_OR, OP_XOR, OP_NOT,
            OP_ADI, OP_SBI, OP_MVI, OP_ANI, OP_ORI, OP_XRI, OP_NTI,
            OP_LD, OP_IN, OP_LS, OP_RS, OP_RSA: res = 1'b1;
            default:                            res = 1'b0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/dm_ram.sv
// Single-port synchronous data RAM; registered read, read-during-write
// returns the previous contents. Contents are not reset.
module dm_ram #(
    parameter int DEPTH = 256,
    parameter int AW    = 8
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [15:0]   wdata,
    output logic [15:0]   rdata
);

    logic [15:0] mem_r [DEPTH];

    // Write port and registered (old-data) read port.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[addr] <= wdata;
        end
        rdata <= mem_r[addr];
    end

endmodule

// File: rtl/mem_wb_stage.sv
// Memory-access / write-back stage: loads and stores against dm_ram,
// conditional jump resolution, register-file write port and halt state.
module mem_wb_stage
    import mips16_pkg::*;
#(
    parameter int DM_DEPTH = 256,
    parameter int DM_AW    = 8,
    parameter int RF_AW    = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       op_ex,
    input  logic [15:0]      ans_ex,
    input  logic [15:0]      DM_data,
    input  logic [1:0]       flag_ex,
    input  logic [RF_AW-1:0] rd_ex,
    input  logic [15:0]      target_ex,
    output logic             wb_en,
    output logic [RF_AW-1:0] wb_addr,
    output logic [15:0]      wb_data,
    output logic             jump_taken,
    output logic [15:0]      jump_addr,
    output logic             addr_err,
    output logic             halted
);

    wb_state_t        state_r, state_s;
    logic             wb_en_r, wb_en_s;
    logic [RF_AW-1:0] wb_addr_r, wb_addr_s;
    logic [15:0]      wb_data_r, wb_data_s;
    logic             ld_sel_r, ld_sel_s;
    logic             jump_taken_r, jump_taken_s;
    logic [15:0]      jump_addr_r, jump_addr_s;
    logic             addr_err_r, addr_err_s;
    logic             mem_we_s;
    logic             range_err_s;
    logic             is_ld_s, is_st_s, cond_s;
    logic [15:0]      ram_rdata_s;

    assign range_err_s = ((ans_ex >> DM_AW) != 16'd0);
    assign is_ld_s     = (op_ex == OP_LD);
    assign is_st_s     = (op_ex == OP_ST);

    // Jump condition from opcode and flags.
    always_comb begin
        cond_s = 1'b0;
        case (op_ex)
            OP_JMP:  cond_s = 1'b1;
            OP_JV:   cond_s = flag_ex[FLAG_OVF];
            OP_JNV:  cond_s = ~flag_ex[FLAG_OVF];
            OP_JZ:   cond_s = flag_ex[FLAG_ZERO];
            OP_JNZ:  cond_s = ~flag_ex[FLAG_ZERO];
            default: cond_s = 1'b0;
        endcase
    end

    // Next-state and next-output computation; HALT freezes all side effects.
    always_comb begin
        state_s      = state_r;
        wb_en_s      = 1'b0;
        wb_addr_s    = wb_addr_r;
        wb_data_s    = wb_data_r;
        ld_sel_s     = 1'b0;
        jump_taken_s = 1'b0;
        jump_addr_s  = jump_addr_r;
        addr_err_s   = addr_err_r;
        mem_we_s     = 1'b0;
        case (state_r)
            ST_RUN: begin
                if (op_ex == OP_HLT) begin
                    state_s = ST_HALT;
                end else begin
                    state_s = ST_RUN;
                end
                if (writes_back(op_ex)) begin
                    wb_en_s   = 1'b1;
                    wb_addr_s = rd_ex;
                    wb_data_s = (is_ld_s && range_err_s) ? 16'd0 : ans_ex;
                    ld_sel_s  = is_ld_s && !range_err_s;
                end else begin
                    wb_en_s   = 1'b0;
                end
                if (cond_s) begin
                    jump_taken_s = 1'b1;
                    jump_addr_s  = target_ex;
                end else begin
                    jump_taken_s = 1'b0;
                end
                if ((is_ld_s || is_st_s) && range_err_s) begin
                    addr_err_s = 1'b1;
                end else begin
                    addr_err_s = addr_err_r;
                end
                // A store coinciding with reset must not reach the RAM.
                mem_we_s = reset && is_st_s && !range_err_s;
            end
            ST_HALT: state_s = ST_HALT;
            default: state_s = ST_RUN;
        endcase
    end

    // Stage registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r      <= ST_RUN;
            wb_en_r      <= 1'b0;
            wb_addr_r    <= '0;
            wb_data_r    <= 16'd0;
            ld_sel_r     <= 1'b0;
            jump_taken_r <= 1'b0;
            jump_addr_r  <= 16'd0;
            addr_err_r   <= 1'b0;
        end else begin
            state_r      <= state_s;
            wb_en_r      <= wb_en_s;
            wb_addr_r    <= wb_addr_s;
            wb_data_r    <= wb_data_s;
            ld_sel_r     <= ld_sel_s;
            jump_taken_r <= jump_taken_s;
            jump_addr_r  <= jump_addr_s;
            addr_err_r   <= addr_err_s;
        end
    end

    dm_ram #(
        .DEPTH (DM_DEPTH),
        .AW    (DM_AW)
    ) u_dm_ram (
        .clk   (clk),
        .we    (mem_we_s),
        .addr  (ans_ex[DM_AW-1:0]),
        .wdata (DM_data),
        .rdata (ram_rdata_s)
    );

    // Load data comes straight from the RAM's output register.
    assign wb_data    = ld_sel_r ? ram_rdata_s : wb_data_r;
    assign wb_en      = wb_en_r;
    assign wb_addr    = wb_addr_r;
    assign jump_taken = jump_taken_r;
    assign jump_addr  = jump_addr_r;
    assign addr_err   = addr_err_r;
    assign halted     = (state_r == ST_HALT);

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage: reset, load/store, write-back, range
// errors, jumps and halt, each checked one cycle after the op is presented.
module tb_mem_wb_stage;
    import mips16_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [5:0]  op_ex = OP_OUT;
    logic [15:0] ans_ex = 16'd0;
    logic [15:0] DM_data = 16'd0;
    logic [1:0]  flag_ex = 2'b00;
    logic [2:0]  rd_ex = 3'd0;
    logic [15:0] target_ex = 16'd0;
    logic        wb_en;
    logic [2:0]  wb_addr;
    logic [15:0] wb_data;
    logic        jump_taken;
    logic [15:0] jump_addr;
    logic        addr_err;
    logic        halted;

    int total = 0;
    int passed = 0;

    mem_wb_stage #(.DM_DEPTH(256), .DM_AW(8), .RF_AW(3)) dut (
        .clk(clk), .reset(reset), .op_ex(op_ex), .ans_ex(ans_ex),
        .DM_data(DM_data), .flag_ex(flag_ex), .rd_ex(rd_ex),
        .target_ex(target_ex), .wb_en(wb_en), .wb_addr(wb_addr),
        .wb_data(wb_data), .jump_taken(jump_taken), .jump_addr(jump_addr),
        .addr_err(addr_err), .halted(halted)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic step(input logic [5:0] op, input logic [15:0] ans, input logic [15:0] dat,
                        input logic [1:0] flg, input logic [2:0] rd, input logic [15:0] tgt);
        op_ex = op; ans_ex = ans; DM_data = dat; flag_ex = flg; rd_ex = rd; target_ex = tgt;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_wb_en"}, {15'd0, wb_en}, 16'd0);
        chk({tag, "_wb_addr"}, {13'd0, wb_addr}, 16'd0);
        chk({tag, "_wb_data"}, wb_data, 16'd0);
        chk({tag, "_jt"}, {15'd0, jump_taken}, 16'd0);
        chk({tag, "_ja"}, jump_addr, 16'd0);
        chk({tag, "_err"}, {15'd0, addr_err}, 16'd0);
        chk({tag, "_halted"}, {15'd0, halted}, 16'd0);
    endtask

    initial begin
        // Reset held with a store presented: outputs zero, store dropped.
        reset = 1'b0;
        step(OP_ST, 16'd5, 16'hBEEF, 2'b00, 3'd0, 16'd0);
        chk_zero("rst1");
        step(OP_ST, 16'd5, 16'hBEEF, 2'b00, 3'd0, 16'd0);
        chk_zero("rst2");
        reset = 1'b1;
        step(OP_LD, 16'd5, 16'd0, 2'b00, 3'd2, 16'd0);
        chk("rst_ld_en", {15'd0, wb_en}, 16'd1);
        chk("rst_ld_addr", {13'd0, wb_addr}, 16'd2);
        total++;
        assert (wb_data !== 16'hBEEF) passed++;
        else $error("FAIL rst_store_dropped: observed %h expected not BEEF", wb_data);

        // Back-to-back store then load of the same address.
        step(OP_ST, 16'h0012, 16'h1234, 2'b00, 3'd0, 16'd0);
        chk("st_wb_en", {15'd0, wb_en}, 16'd0);
        step(OP_LD, 16'h0012, 16'd0, 2'b00, 3'd3, 16'd0);
        chk("ld_en", {15'd0, wb_en}, 16'd1);
        chk("ld_addr", {13'd0, wb_addr}, 16'd3);
        chk("ld_data", wb_data, 16'h1234);

        // ALU write-back, then a non-writing op.
        step(OP_ADD, 16'h00FF, 16'd0, 2'b00, 3'd7, 16'd0);
        chk("add_en", {15'd0, wb_en}, 16'd1);
        chk("add_addr", {13'd0, wb_addr}, 16'd7);
        chk("add_data", wb_data, 16'h00FF);
        step(OP_OUT, 16'h0077, 16'd0, 2'b00, 3'd6, 16'd0);
        chk("out_en", {15'd0, wb_en}, 16'd0);

        // Out-of-range store must not alias onto address 0.
        step(OP_ST, 16'h0000, 16'hA5A5, 2'b00, 3'd0, 16'd0);
        chk("st0_err", {15'd0, addr_err}, 16'd0);
        step(OP_ST, 16'h0100, 16'h5A5A, 2'b00, 3'd0, 16'd0);
        chk("oor_st_err", {15'd0, addr_err}, 16'd1);
        step(OP_LD, 16'h0000, 16'd0, 2'b00, 3'd4, 16'd0);
        chk("ld0_data", wb_data, 16'hA5A5);
        step(OP_LD, 16'h0205, 16'd0, 2'b00, 3'd5, 16'd0);
        chk("oor_ld_en", {15'd0, wb_en}, 16'd1);
        chk("oor_ld_addr", {13'd0, wb_addr}, 16'd5);
        chk("oor_ld_data", wb_data, 16'd0);
        for (int i = 0; i < 10; i++) begin
            step(OP_SUB, 16'h0100 + 16'(i), 16'd0, 2'b00, 3'(i), 16'd0);
            chk("err_sticky", {15'd0, addr_err}, 16'd1);
            chk("alu_data", wb_data, 16'h0100 + 16'(i));
        end

        // Conditional jumps and pulse width.
        step(OP_JZ, 16'd0, 16'd0, 2'b10, 3'd0, 16'h0040);
        chk("jz_taken", {15'd0, jump_taken}, 16'd1);
        chk("jz_addr", jump_addr, 16'h0040);
        chk("jz_wb_en", {15'd0, wb_en}, 16'd0);
        step(OP_JNZ, 16'd0, 16'd0, 2'b10, 3'd0, 16'h0050);
        chk("jnz_taken", {15'd0, jump_taken}, 16'd0);
        step(OP_JNV, 16'd0, 16'd0, 2'b00, 3'd0, 16'h0080);
        chk("jnv_taken", {15'd0, jump_taken}, 16'd1);
        chk("jnv_addr", jump_addr, 16'h0080);
        step(OP_JV, 16'd0, 16'd0, 2'b10, 3'd0, 16'h0090);
        chk("jv_taken", {15'd0, jump_taken}, 16'd0);
        step(OP_JV, 16'd0, 16'd0, 2'b01, 3'd0, 16'h00A0);
        chk("jv1_taken", {15'd0, jump_taken}, 16'd1);
        chk("jv1_addr", jump_addr, 16'h00A0);
        step(6'd60, 16'h0033, 16'd0, 2'b11, 3'd2, 16'h00B0);
        chk("undef_en", {15'd0, wb_en}, 16'd0);
        chk("undef_jt", {15'd0, jump_taken}, 16'd0);

        // Halt: no pulses or stores until reset.
        step(OP_HLT, 16'h0011, 16'd0, 2'b00, 3'd1, 16'd0);
        chk("hlt_en", {15'd0, wb_en}, 16'd0);
        chk("hlt_halted", {15'd0, halted}, 16'd1);
        step(OP_ADD, 16'h0022, 16'd0, 2'b00, 3'd1, 16'd0);
        chk("halt_add_en", {15'd0, wb_en}, 16'd0);
        chk("halt_add_halted", {15'd0, halted}, 16'd1);
        step(OP_JMP, 16'd0, 16'd0, 2'b00, 3'd0, 16'h0123);
        chk("halt_jmp", {15'd0, jump_taken}, 16'd0);
        step(OP_ST, 16'h0012, 16'hFFFF, 2'b00, 3'd0, 16'd0);
        chk("halt_st_halted", {15'd0, halted}, 16'd1);
        reset = 1'b0;
        step(OP_ADD, 16'h0099, 16'd0, 2'b00, 3'd1, 16'd0);
        chk_zero("rst_halt");
        reset = 1'b1;
        step(OP_ADD, 16'h0042, 16'd0, 2'b00, 3'd1, 16'd0);
        chk("post_add_en", {15'd0, wb_en}, 16'd1);
        chk("post_add_addr", {13'd0, wb_addr}, 16'd1);
        chk("post_add_data", wb_data, 16'h0042);
        chk("post_halted", {15'd0, halted}, 16'd0);
        step(OP_LD, 16'h0012, 16'd0, 2'b00, 3'd6, 16'd0);
        chk("halt_st_blocked", wb_data, 16'h1234);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
